// File: rtl/hist_acq_scheduler.sv
// Acquisition controller and round-robin write-port arbiter for the histogram builder.
// Clears the histogram, counts laser periods and funnels pixel timestamps onto one write port.
module hist_acq_scheduler #(
  parameter int NP    = 10,
  parameter int N_PIX = 3,
  parameter int CYC_W = 16,
  parameter int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [CYC_W-1:0]      num_cycles,
  input  logic                  laser_sync,
  input  logic [N_PIX-1:0]      req_valid,
  input  logic [N_PIX*NP-1:0]   req_data,
  output logic [N_PIX-1:0]      req_ready,
  output logic                  wr_en,
  output logic [PIX_W-1:0]      wr_pix,
  output logic [NP-1:0]         wr_data,
  output logic                  hist_clr,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  // Handshake: a channel transfers in any cycle where req_valid[i] & req_ready[i];
  // req_ready is one-hot or zero and never asserted toward a channel that is not valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CYC_W-1:0] n_lat;
  logic [CYC_W-1:0] cnt;
  logic [PIX_W-1:0] ptr;
  logic [PIX_W-1:0] gnt_idx;
  logic [PIX_W:0]   idx;
  logic             gnt_any;
  logic             grant_en;
  logic             term_sync;
  logic [NP-1:0]    gnt_data;
  logic [NP-1:0]    ch_data [N_PIX];

  for (genvar g = 0; g < N_PIX; g++) begin : g_unpack
    assign ch_data[g] = req_data[g*NP +: NP];
  end

  // n_lat is never 0 in RUN, so the subtraction cannot underflow there.
  assign term_sync = (state == S_RUN) && laser_sync && (cnt == n_lat - CYC_W'(1));

  always_comb begin
    state_nx = state;
    grant_en = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = (n_lat == '0) ? S_DONE : S_ARM;
      S_ARM:   if (laser_sync) state_nx = S_RUN;
      S_RUN: begin
        grant_en = !term_sync;
        if (term_sync) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Round-robin search starting at ptr, wrapping modulo N_PIX.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    req_ready = '0;
    for (int k = 0; k < N_PIX; k++) begin
      idx = {1'b0, ptr} + (PIX_W+1)'(k);
      if (idx >= (PIX_W+1)'(N_PIX)) idx = idx - (PIX_W+1)'(N_PIX);
      if (grant_en && !gnt_any && req_valid[idx[PIX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[PIX_W-1:0];
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
    gnt_data = ch_data[gnt_idx];
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= S_IDLE;
      n_lat <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) n_lat <= num_cycles;
      if (state == S_ARM && laser_sync) cnt <= '0;
      else if (state == S_RUN && laser_sync && !term_sync) cnt <= cnt + CYC_W'(1);
      if (gnt_any) ptr <= (gnt_idx == PIX_W'(N_PIX - 1)) ? '0 : gnt_idx + PIX_W'(1);
    end
  end

  // Zero timestamps mean "no photon": consumed by the handshake but never written.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_en   <= 1'b0;
      wr_pix  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= gnt_any && (gnt_data != '0);
      if (gnt_any && (gnt_data != '0)) begin
        wr_pix  <= gnt_idx;
        wr_data <= gnt_data;
      end
    end
  end

  assign hist_clr  = (state == S_CLEAR);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_hist_acq_scheduler.sv
// Bench for hist_acq_scheduler: cycle-by-cycle vector table plus directed
// acquisition sequences with a round-robin model and a write scoreboard.
module tb_hist_acq_scheduler;
  localparam int NP    = 10;
  localparam int N_PIX = 3;
  localparam int CYC_W = 16;
  localparam int PIX_W = 2;

  logic                clk;
  logic                res;
  logic                start;
  logic [CYC_W-1:0]    num_cycles;
  logic                laser_sync;
  logic [N_PIX-1:0]    req_valid;
  logic [N_PIX*NP-1:0] req_data;
  logic [N_PIX-1:0]    req_ready;
  logic                wr_en;
  logic [PIX_W-1:0]    wr_pix;
  logic [NP-1:0]       wr_data;
  logic                hist_clr;
  logic                busy;
  logic                done;
  logic [2:0]          state_dbg;

  hist_acq_scheduler #(.NP(NP), .N_PIX(N_PIX), .CYC_W(CYC_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .res(res), .start(start), .num_cycles(num_cycles),
    .laser_sync(laser_sync), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_pix(wr_pix), .wr_data(wr_data),
    .hist_clr(hist_clr), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int model_ptr = 0;
  logic [PIX_W+NP-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_data(input logic [NP-1:0] d0, input logic [NP-1:0] d1, input logic [NP-1:0] d2);
    req_data = {d2, d1, d0};
  endtask

  typedef struct {
    logic             start;
    logic [CYC_W-1:0] nc;
    logic             sync;
    logic [2:0]       valid;
    logic [NP-1:0]    d0, d1, d2;
    logic [2:0]       e_ready;
    logic             e_wr;
    logic [PIX_W-1:0] e_pix;
    logic [NP-1:0]    e_data;
    logic             e_clr, e_busy, e_done;
  } vec_t;

  function automatic vec_t mk(logic st, logic [CYC_W-1:0] nc, logic sy, logic [2:0] va,
                              logic [NP-1:0] d0, logic [NP-1:0] d1, logic [NP-1:0] d2,
                              logic [2:0] rdy, logic we, logic [PIX_W-1:0] pix, logic [NP-1:0] dat,
                              logic clr, logic bsy, logic dn);
    vec_t v;
    v.start = st; v.nc = nc; v.sync = sy; v.valid = va;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.e_ready = rdy; v.e_wr = we; v.e_pix = pix; v.e_data = dat;
    v.e_clr = clr; v.e_busy = bsy; v.e_done = dn;
    return v;
  endfunction

  vec_t vecs[20];

  // One full acquisition with syncs every `period` cycles starting at cycle 3.
  task automatic run_acq(input int nc, input int period, input bit stray);
    int exp_done_cyc, win_end, busy_cnt, wr_cnt, gnt_cnt;
    logic [NP-1:0] dv [N_PIX];
    logic [2:0] exp_ready;
    logic [PIX_W+NP-1:0] e;
    dv[0] = 10'd108; dv[1] = 10'd511; dv[2] = 10'd1023;
    exp_done_cyc = (nc == 0) ? 2 : 3 + nc * period + 1;
    win_end      = (nc == 0) ? 0 : 3 + nc * period;
    busy_cnt = 0; wr_cnt = 0; gnt_cnt = 0;
    exp_q.delete();
    for (int cyc = 0; cyc <= exp_done_cyc + 3; cyc++) begin
      @(negedge clk);
      start      = (cyc == 0) || (stray && cyc == 10);
      num_cycles = (cyc == 0) ? CYC_W'(nc) : ((cyc == 10) ? CYC_W'(5) : 16'hABCD);
      laser_sync = (cyc >= 3) && (((cyc - 3) % period) == 0);
      req_valid  = 3'b111;
      set_data(dv[0], dv[1], dv[2]);
      #1;
      exp_ready = (cyc >= 4 && cyc < win_end) ? 3'(1 << model_ptr) : 3'b000;
      chk($sformatf("acq nc%0d c%0d ready", nc, cyc), 32'(req_ready), 32'(exp_ready));
      chk($sformatf("acq nc%0d c%0d clr", nc, cyc), 32'(hist_clr), 32'(cyc == 1));
      chk($sformatf("acq nc%0d c%0d done", nc, cyc), 32'(done), 32'(cyc == exp_done_cyc));
      chk($sformatf("acq nc%0d c%0d busy", nc, cyc), 32'(busy), 32'(cyc >= 1 && cyc <= exp_done_cyc));
      chk($sformatf("acq nc%0d c%0d wr_en", nc, cyc), 32'(wr_en), 32'(exp_q.size() != 0));
      if (busy) busy_cnt++;
      if (wr_en) wr_cnt++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (wr_en) begin
          chk($sformatf("acq nc%0d c%0d wr_pix", nc, cyc), 32'(wr_pix), 32'(e[PIX_W+NP-1:NP]));
          chk($sformatf("acq nc%0d c%0d wr_data", nc, cyc), 32'(wr_data), 32'(e[NP-1:0]));
        end
      end
      if (exp_ready != 3'b000) begin
        gnt_cnt++;
        exp_q.push_back({PIX_W'(model_ptr), dv[model_ptr]});
        model_ptr = (model_ptr + 1) % N_PIX;
      end
    end
    start = 1'b0; laser_sync = 1'b0; req_valid = 3'b000;
    chk($sformatf("acq nc%0d busy cycles", nc), 32'(busy_cnt), 32'(exp_done_cyc));
    chk($sformatf("acq nc%0d wr count", nc), 32'(wr_cnt), 32'(gnt_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got 0, expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b0; start = 1'b0; num_cycles = '0; laser_sync = 1'b0;
    req_valid = 3'b111; set_data(10'd1, 10'd2, 10'd3);

    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", 32'(req_ready), 0);
    chk("reset wr_en", 32'(wr_en), 0);
    chk("reset wr_pix", 32'(wr_pix), 0);
    chk("reset wr_data", 32'(wr_data), 0);
    chk("reset clr", 32'(hist_clr), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset state", 32'(state_dbg), 0);
    @(negedge clk);
    res = 1'b1; req_valid = 3'b000;

    // round-robin, num_cycles=1
    vecs[0]  = mk(1, 1, 0, 3'b111, 108, 511, 1023, 3'b000, 0, 0, 0,    0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 3'b111, 108, 511, 1023, 3'b000, 0, 0, 0,    1, 1, 0);
    vecs[2]  = mk(0, 1, 0, 3'b111, 108, 511, 1023, 3'b000, 0, 0, 0,    0, 1, 0);
    vecs[3]  = mk(0, 1, 1, 3'b111, 108, 511, 1023, 3'b000, 0, 0, 0,    0, 1, 0);
    vecs[4]  = mk(0, 1, 0, 3'b111, 108, 511, 1023, 3'b001, 0, 0, 0,    0, 1, 0);
    vecs[5]  = mk(0, 1, 0, 3'b111, 108, 511, 1023, 3'b010, 1, 0, 108,  0, 1, 0);
    vecs[6]  = mk(0, 1, 0, 3'b111, 108, 511, 1023, 3'b100, 1, 1, 511,  0, 1, 0);
    vecs[7]  = mk(0, 1, 0, 3'b111, 108, 511, 1023, 3'b001, 1, 2, 1023, 0, 1, 0);
    vecs[8]  = mk(0, 1, 1, 3'b111, 108, 511, 1023, 3'b000, 1, 0, 108,  0, 1, 0);
    vecs[9]  = mk(0, 1, 0, 3'b111, 108, 511, 1023, 3'b000, 0, 0, 0,    0, 1, 1);
    vecs[10] = mk(0, 1, 0, 3'b000, 108, 511, 1023, 3'b000, 0, 0, 0,    0, 0, 0);
    // zero filter on channel 1, ptr now 1
    vecs[11] = mk(1, 1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 0, 0,  0, 0, 0);
    vecs[12] = mk(0, 1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 0, 0,  1, 1, 0);
    vecs[13] = mk(0, 1, 1, 3'b000, 0, 0,  0, 3'b000, 0, 0, 0,  0, 1, 0);
    vecs[14] = mk(0, 1, 0, 3'b010, 0, 0,  0, 3'b010, 0, 0, 0,  0, 1, 0);
    vecs[15] = mk(0, 1, 0, 3'b010, 0, 90, 0, 3'b010, 0, 0, 0,  0, 1, 0);
    vecs[16] = mk(0, 1, 0, 3'b000, 0, 0,  0, 3'b000, 1, 1, 90, 0, 1, 0);
    vecs[17] = mk(0, 1, 1, 3'b000, 0, 0,  0, 3'b000, 0, 0, 0,  0, 1, 0);
    vecs[18] = mk(0, 1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 0, 0,  0, 1, 1);
    vecs[19] = mk(0, 1, 0, 3'b000, 0, 0,  0, 3'b000, 0, 0, 0,  0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = vecs[i].start; num_cycles = vecs[i].nc; laser_sync = vecs[i].sync;
      req_valid = vecs[i].valid; set_data(vecs[i].d0, vecs[i].d1, vecs[i].d2);
      #1;
      chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr));
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d wr_pix", i), 32'(wr_pix), 32'(vecs[i].e_pix));
        chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(vecs[i].e_data));
      end
      chk($sformatf("v%0d clr", i), 32'(hist_clr), 32'(vecs[i].e_clr));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
    end
    start = 1'b0; laser_sync = 1'b0; req_valid = 3'b000;
    model_ptr = 2;

    run_acq(0, 8, 1'b0);
    run_acq(3, 8, 1'b0);
    run_acq(2, 8, 1'b1);
    run_acq(1, 1, 1'b0);
    run_acq(2, 5, 1'b0);

    // reset in the middle of RUN
    @(negedge clk); start = 1'b1; num_cycles = 16'd4; req_valid = 3'b111;
    set_data(10'd108, 10'd511, 10'd1023);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); laser_sync = 1'b1;
    @(negedge clk); laser_sync = 1'b0;
    #1;
    chk("mid-run ready", 32'(req_ready), 32'(1 << model_ptr));
    @(negedge clk);
    #1;
    chk("mid-run wr_en", 32'(wr_en), 1);
    res = 1'b0;
    #1;
    chk("async rst ready", 32'(req_ready), 0);
    chk("async rst wr_en", 32'(wr_en), 0);
    chk("async rst wr_pix", 32'(wr_pix), 0);
    chk("async rst wr_data", 32'(wr_data), 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst done", 32'(done), 0);
    chk("async rst state", 32'(state_dbg), 0);
    @(negedge clk); res = 1'b1;
    #1;
    chk("post rst state", 32'(state_dbg), 0);
    chk("post rst busy", 32'(busy), 0);
    chk("post rst done", 32'(done), 0);
    @(negedge clk); start = 1'b1; num_cycles = 16'd1;
    #1;
    chk("post rst start clr", 32'(hist_clr), 0);
    @(negedge clk); start = 1'b0;
    #1;
    chk("post rst clr pulse", 32'(hist_clr), 1);
    chk("post rst busy high", 32'(busy), 1);
    @(negedge clk);
    #1;
    chk("post rst clr end", 32'(hist_clr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
